// File: rtl/adder_pipelined_if.sv
// -----------------------------------------------------------------------------
// adder_pipelined_if
//
// Operand/result bundle for adder_pipelined.
//
// Signals
//   in_valid  : a, b and sub carry an operation this cycle
//   sub       : 0 = a+b, 1 = a-b
//   a, b      : ADDER_WIDTH-bit operands (unsigned or two's complement)
//   out_valid : sum carries a result
//   sum       : ADDER_WIDTH+1-bit result, top bit is the carry-out
//
// Modports
//   master : operation source / result sink (drives a, b, sub, in_valid)
//   slave  : the adder itself (drives sum, out_valid)
// -----------------------------------------------------------------------------
interface adder_pipelined_if #(
    parameter int ADDER_WIDTH = 92
);
    logic                   in_valid;
    logic                   sub;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   out_valid;
    logic [ADDER_WIDTH:0]   sum;

    modport master (
        output in_valid,
        output sub,
        output a,
        output b,
        input  out_valid,
        input  sum
    );

    modport slave (
        input  in_valid,
        input  sub,
        input  a,
        input  b,
        output out_valid,
        output sum
    );
endinterface

// File: rtl/adder_pipelined.sv
// -----------------------------------------------------------------------------
// adder_pipelined
//
// Fully pipelined ripple-segment adder/subtractor. The W-bit carry chain is
// split into STAGES registered segments of SEG = ceil(W/STAGES) bits; the top
// segment takes whatever remains. One operation is accepted per enabled cycle
// and the result appears STAGES+1 enabled edges after it was sampled.
//
// Subtraction is a + ~b + 1: b is inverted at capture and the carry-in of the
// bottom segment is the sub bit, so sum[W] is the inverted borrow (1 iff
// a >= b unsigned).
//
// Ports
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; clears all data, carry and valid
//           registers and overrides ce
//   ce    : clock enable; while low every register (outputs included) holds
//   bus   : adder_pipelined_if.slave (in_valid, sub, a, b -> out_valid, sum)
// -----------------------------------------------------------------------------
module adder_pipelined #(
    parameter int ADDER_WIDTH = 92,
    parameter int STAGES      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    adder_pipelined_if.slave bus
);
    localparam int W    = ADDER_WIDTH;
    localparam int S    = STAGES;
    localparam int SEG  = (W + S - 1) / S;
    localparam int LAST = W - (S - 1) * SEG;

    if (W < 1 || S < 1 || S > W || LAST < 1) begin : g_bad_params
        $error("adder_pipelined: illegal ADDER_WIDTH/STAGES combination");
    end

    // r_q[k] holds the already computed low k segments of the result in its
    // low bits and the not-yet-consumed segments of operand a above them, so
    // one vector per stage carries both the partial result and the pending
    // operand. b_q[k] carries (possibly inverted) operand b; stage S needs
    // no copy of b, so its array stops at S-1.
    logic [W-1:0] r_q   [0:S];
    logic [W-1:0] r_d   [0:S];
    logic [W-1:0] b_q   [0:S-1];
    logic [W-1:0] b_d   [0:S-1];
    logic         c_q   [0:S];
    logic         c_d   [0:S];
    logic         vld_q [0:S];
    logic         vld_d [0:S];

    // ---- register stage 0: operand capture ----
    // Data loads every enabled cycle; in_valid only travels alongside.
    assign r_d[0]   = bus.a;
    assign b_d[0]   = bus.sub ? ~bus.b : bus.b;
    assign c_d[0]   = bus.sub;
    assign vld_d[0] = bus.in_valid;

    // ---- register stages 1..S: one segment add per stage ----
    for (genvar k = 1; k <= S; k++) begin : g_seg
        localparam int LO = (k - 1) * SEG;
        localparam int SW = (k == S) ? LAST : SEG;

        logic [SW:0]  seg_sum;
        logic [W-1:0] nxt;

        // The only combinational path of the stage: an SW-bit add plus the
        // carry registered by the previous stage.
        assign seg_sum = {1'b0, r_q[k-1][LO +: SW]}
                       + {1'b0, b_q[k-1][LO +: SW]}
                       + {{SW{1'b0}}, c_q[k-1]};

        // Low results and pending high a segments are delayed unchanged;
        // only this stage's segment is replaced by its sum.
        always_comb begin
            nxt           = r_q[k-1];
            nxt[LO +: SW] = seg_sum[SW-1:0];
        end

        assign r_d[k]   = nxt;
        assign c_d[k]   = seg_sum[SW];
        assign vld_d[k] = vld_q[k-1];

        if (k < S) begin : g_pass_b
            assign b_d[k] = b_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '{default: '0};
            b_q   <= '{default: '0};
            c_q   <= '{default: 1'b0};
            vld_q <= '{default: 1'b0};
        end else if (ce) begin
            r_q   <= r_d;
            b_q   <= b_d;
            c_q   <= c_d;
            vld_q <= vld_d;
        end
    end

    // ---- output: stage S ----
    assign bus.sum       = {c_q[S], r_q[S]};
    assign bus.out_valid = vld_q[S];

endmodule

// File: tb/tb_adder_pipelined.sv
module tb_adder_pipelined;
    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   n_cmp = 0;
    int   n_bad = 0;

    adder_pipelined_if #(.ADDER_WIDTH(92)) if0 ();
    adder_pipelined_if #(.ADDER_WIDTH(10)) if1 ();
    adder_pipelined_if #(.ADDER_WIDTH(92)) if2 ();

    adder_pipelined #(.ADDER_WIDTH(92), .STAGES(4)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .bus(if0));
    adder_pipelined #(.ADDER_WIDTH(10), .STAGES(3)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .bus(if1));
    adder_pipelined #(.ADDER_WIDTH(92), .STAGES(1)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .bus(if2));

    always #5 clk = ~clk;

    localparam logic [92:0] P92  = 93'd1 << 92;
    localparam logic [91:0] P91  = 92'd1 << 91;
    localparam logic [91:0] ALL1 = '1;

    logic [91:0] sa [40];
    logic [91:0] sb [40];
    logic        ss [40];
    logic        sv [40];
    logic [92:0] se [40];
    logic [92:0] e0, e1, e2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic s, input logic [91:0] a, input logic [91:0] b);
        if0.in_valid = v; if0.sub = s; if0.a = a; if0.b = b;
    endtask

    task automatic drv1(input logic v, input logic s, input logic [9:0] a, input logic [9:0] b);
        if1.in_valid = v; if1.sub = s; if1.a = a; if1.b = b;
    endtask

    task automatic drv2(input logic v, input logic s, input logic [91:0] a, input logic [91:0] b);
        if2.in_valid = v; if2.sub = s; if2.a = a; if2.b = b;
    endtask

    task automatic flush0(input int n);
        drv0(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference arithmetic: exact add; subtract gives (a-b) mod 2^92 with the
    // inverted borrow on top.
    function automatic logic [92:0] ref92(input logic [91:0] a, input logic [91:0] b, input logic s);
        if (!s) return {1'b0, a} + {1'b0, b};
        return {(a >= b), a - b};
    endfunction

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        drv0(1'b0, 1'b0, '0, '0);
        drv1(1'b0, 1'b0, '0, '0);
        drv2(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check("rst_sum0", 96'(if0.sum), 96'd0);
        check("rst_vld0", 96'(if0.out_valid), 96'd0);
        check("rst_sum1", 96'(if1.sum), 96'd0);
        check("rst_vld1", 96'(if1.out_valid), 96'd0);
        check("rst_sum2", 96'(if2.sum), 96'd0);
        check("rst_vld2", 96'(if2.out_valid), 96'd0);
        reset = 1'b0;

        // Full carry ripple across all four segments, single slot.
        drv0(1'b1, 1'b0, ALL1, 92'd1);
        tick();
        drv0(1'b0, 1'b0, '0, '0);
        for (int i = 2; i <= 6; i++) begin
            tick();
            check($sformatf("ripple_vld_t%0d", i), 96'(if0.out_valid), 96'(i == 5));
            if (i == 5) check("ripple_sum", 96'(if0.sum), 96'(P92));
        end

        // Back-to-back subtracts with and without borrow.
        drv0(1'b1, 1'b1, 92'd5, 92'd7);
        tick();
        drv0(1'b1, 1'b1, 92'd7, 92'd5);
        tick();
        drv0(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check("sub_early_vld", 96'(if0.out_valid), 96'd0);
        tick();
        check("sub_b_vld", 96'(if0.out_valid), 96'd1);
        check("sub_b_sum", 96'(if0.sum), 96'(P92 - 93'd2));
        tick();
        check("sub_nb_vld", 96'(if0.out_valid), 96'd1);
        check("sub_nb_sum", 96'(if0.sum), 96'(P92 + 93'd2));
        tick();
        check("sub_after_vld", 96'(if0.out_valid), 96'd0);

        // Stall: three ops, ce low for four cycles (inputs ignored), then a
        // second stall while the first result is on the output.
        flush0(6);
        e0 = ref92(ALL1, ALL1, 1'b0);
        e1 = ref92(92'd100, 92'd300, 1'b1);
        e2 = ref92(92'h123456789ABCDEF, 92'd1, 1'b0);
        drv0(1'b1, 1'b0, ALL1, ALL1);
        tick();
        drv0(1'b1, 1'b1, 92'd100, 92'd300);
        tick();
        drv0(1'b1, 1'b0, 92'h123456789ABCDEF, 92'd1);
        tick();
        ce = 1'b0;
        drv0(1'b1, 1'b1, ALL1, 92'd3);
        for (int i = 4; i <= 7; i++) begin
            tick();
            check($sformatf("stall_vld_t%0d", i), 96'(if0.out_valid), 96'd0);
            check($sformatf("stall_sum_t%0d", i), 96'(if0.sum), 96'd0);
        end
        ce = 1'b1;
        drv0(1'b0, 1'b0, '0, '0);
        tick();
        check("stall_r0_early", 96'(if0.out_valid), 96'd0);
        tick();
        check("stall_r0_vld", 96'(if0.out_valid), 96'd1);
        check("stall_r0_sum", 96'(if0.sum), 96'(e0));
        ce = 1'b0;
        tick();
        tick();
        check("stall_hold_vld", 96'(if0.out_valid), 96'd1);
        check("stall_hold_sum", 96'(if0.sum), 96'(e0));
        ce = 1'b1;
        tick();
        check("stall_r1_vld", 96'(if0.out_valid), 96'd1);
        check("stall_r1_sum", 96'(if0.sum), 96'(e1));
        tick();
        check("stall_r2_vld", 96'(if0.out_valid), 96'd1);
        check("stall_r2_sum", 96'(if0.sum), 96'(e2));
        tick();
        check("stall_end_vld", 96'(if0.out_valid), 96'd0);

        // Reset mid-flight: reset at the edge two cycles after the first op.
        flush0(6);
        drv0(1'b1, 1'b0, ALL1, 92'd1);
        tick();
        drv0(1'b1, 1'b1, 92'd9, 92'd4);
        tick();
        drv0(1'b1, 1'b0, 92'd11, 92'd22);
        reset = 1'b1;
        tick();
        check("rmid_sum", 96'(if0.sum), 96'd0);
        check("rmid_vld", 96'(if0.out_valid), 96'd0);
        reset = 1'b0;
        drv0(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("rmid_gone_vld_%0d", i), 96'(if0.out_valid), 96'd0);
            check($sformatf("rmid_gone_sum_%0d", i), 96'(if0.sum), 96'd0);
        end

        // Reset while ce is low still clears a visible result.
        drv0(1'b1, 1'b0, ALL1, 92'd1);
        tick();
        drv0(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) tick();
        check("rce_pre_vld", 96'(if0.out_valid), 96'd1);
        check("rce_pre_sum", 96'(if0.sum), 96'(P92));
        ce    = 1'b0;
        reset = 1'b1;
        tick();
        check("rce_sum", 96'(if0.sum), 96'd0);
        check("rce_vld", 96'(if0.out_valid), 96'd0);
        reset = 1'b0;
        ce    = 1'b1;

        // Streaming: 20 ops back-to-back, then 20 with random in_valid.
        for (int i = 0; i < 40; i++) begin
            sa[i] = 92'({$urandom, $urandom, $urandom});
            sb[i] = 92'({$urandom, $urandom, $urandom});
            ss[i] = 1'($urandom_range(0, 1));
            sv[i] = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        sb[3] = sa[3];
        ss[3] = 1'b1;
        sa[4] = ALL1;
        sb[4] = ALL1;
        ss[4] = 1'b1;
        sa[5] = '0;
        sb[5] = 92'd1;
        ss[5] = 1'b1;
        for (int i = 0; i < 40; i++) se[i] = ref92(sa[i], sb[i], ss[i]);
        for (int t = 0; t < 44; t++) begin
            if (t < 40) drv0(sv[t], ss[t], sa[t], sb[t]);
            else        drv0(1'b0, 1'b0, '0, '0);
            tick();
            if (t >= 4) begin
                check($sformatf("strm_vld_%0d", t - 4), 96'(if0.out_valid), 96'(sv[t-4]));
                if (sv[t-4]) check($sformatf("strm_sum_%0d", t - 4), 96'(if0.sum), 96'(se[t-4]));
            end
        end
        drv0(1'b0, 1'b0, '0, '0);

        // Uneven segmentation W=10, S=3 (4,4,2): latency 4.
        drv1(1'b1, 1'b0, 10'd1023, 10'd1);
        tick();
        check("w10_t1_vld", 96'(if1.out_valid), 96'd0);
        drv1(1'b1, 1'b1, 10'd3, 10'd5);
        tick();
        drv1(1'b1, 1'b0, 10'd1023, 10'd1023);
        tick();
        check("w10_t3_vld", 96'(if1.out_valid), 96'd0);
        drv1(1'b0, 1'b0, '0, '0);
        tick();
        check("w10_r0_vld", 96'(if1.out_valid), 96'd1);
        check("w10_r0_sum", 96'(if1.sum), 96'd1024);
        tick();
        check("w10_r1_vld", 96'(if1.out_valid), 96'd1);
        check("w10_r1_sum", 96'(if1.sum), 96'h3FE);
        tick();
        check("w10_r2_vld", 96'(if1.out_valid), 96'd1);
        check("w10_r2_sum", 96'(if1.sum), 96'h7FE);
        tick();
        check("w10_end_vld", 96'(if1.out_valid), 96'd0);

        // Legacy single-segment mode W=92, S=1: latency 2.
        drv2(1'b1, 1'b0, P91, P91);
        tick();
        check("s1_t1_vld", 96'(if2.out_valid), 96'd0);
        drv2(1'b1, 1'b1, P91, 92'd1);
        tick();
        check("s1_r0_vld", 96'(if2.out_valid), 96'd1);
        check("s1_r0_sum", 96'(if2.sum), 96'(P92));
        drv2(1'b0, 1'b0, '0, '0);
        tick();
        check("s1_r1_vld", 96'(if2.out_valid), 96'd1);
        check("s1_r1_sum", 96'(if2.sum), 96'(P92) + 96'(P91) - 96'd1);
        tick();
        check("s1_end_vld", 96'(if2.out_valid), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
